fragment_to_chunk_flush: RTL and testbench
==========================================

# fragment_to_chunk_flush

Packs variable-size upstream data fragments into fixed-size downstream chunks, with end-of-frame flush. A fragment may carry a `last` marker; the remaining partial data is then emitted as a short chunk tagged with its valid size and `last`. The block sits between a variable-rate producer (parser, decompressor) and a fixed-width consumer. It uses a parametrised circular element buffer with proper valid/ready handshakes on both sides.

## Interface
- `S_MAX_IN`, 4: max elements per input fragment; must be ≥1.
- `S_OUT`, 8: elements per output chunk; must be ≥ `S_MAX_IN`.
- `BUF_CAP`, 2*`S_OUT`: buffer capacity in elements; must be ≥ `S_OUT`+`S_MAX_IN`; need not be a power of two.
- `T`, logic: element type.
- Any parameter violation is an elaboration-time `$error`.

Ports:
- `i_clk`  in  1  clock.
- `i_sync_rst_n`  in  1  synchronous reset, active-low.
- `i_frag_valid`  in  1  fragment valid.
- `i_frag_size`  in  $clog2(`S_MAX_IN`+1)  element count; values > `S_MAX_IN` are clipped.
- `i_frag_last`  in  1  fragment ends the frame.
- `i_frag`  in  `S_MAX_IN`×T  elements; index 0 is first.
- `o_us_ready`  out  1  block accepts a fragment this cycle.
- `i_ds_ready`  in  1  downstream accepts a chunk.
- `o_chunk_valid`  out  1  chunk valid.
- `o_chunk`  out  `S_OUT`×T  chunk elements; index 0 is oldest.
- `o_chunk_size`  out  $clog2(`S_OUT`+1)  valid element count.
- `o_chunk_last`  out  1  final chunk of the frame.
- `o_clip_err`  out  1  sticky flag: an accepted fragment had size > `S_MAX_IN`.

## Operation
- State:
  - `rd_ptr`, `wr_ptr` in [0, `BUF_CAP`).
  - `cnt` in [0, `BUF_CAP`].
  - `last_pend` flag.
  - `clip_err` flag.
- Push: when `i_frag_valid && o_us_ready`, with `sz` = min(`i_frag_size`, `S_MAX_IN`):
  - element k<`sz` is written to `buf[(wr_ptr+k) mod BUF_CAP]`;
  - `wr_ptr` advances by `sz` mod `BUF_CAP`;
  - `last_pend` is set if `i_frag_last`;
  - `clip_err` is set if `i_frag_size` > `S_MAX_IN`.
- `o_us_ready` = reset deasserted && !`last_pend` && (`BUF_CAP`−`cnt` ≥ `S_MAX_IN`).
  - It has no combinational dependence on `i_ds_ready` or `i_frag_*`.
- `o_chunk_valid` = `cnt` ≥ `S_OUT` || `last_pend`.
- `o_chunk_size` = min(`cnt`, `S_OUT`).
- `o_chunk_last` = `last_pend` && `cnt` ≤ `S_OUT`.
- `o_chunk[k]` = `buf[(rd_ptr+k) mod BUF_CAP]` for k < `o_chunk_size`; otherwise '0.
- Pop: when `o_chunk_valid && i_ds_ready`:
  - `rd_ptr` advances by `o_chunk_size` mod `BUF_CAP`;
  - `cnt` decreases by `o_chunk_size`;
  - `last_pend` is cleared if `o_chunk_last`.
- Simultaneous push and pop: `cnt_next` = `cnt` + `sz` − `o_chunk_size`. The pop uses pre-push state.
- Zero-size fragment:
  - with `last`=0: accepted, no effect on the buffer;
  - with `last`=1: sets `last_pend`.
  - If `cnt`=0 at that point, a chunk with size 0 and `last`=1 is emitted.
- Frame length an exact multiple of `S_OUT`: `last` rides on the final full chunk. No empty chunk is emitted.
- Upstream is stalled while `last_pend`=1. Frames never mix within one chunk.
- Pointer wrap uses an explicit compare-and-subtract. No modulo operator.

## Timing
- Reset (`i_sync_rst_n`=0 at a clock edge) clears:
  - `rd_ptr`, `wr_ptr`, `cnt`;
  - `last_pend`, `clip_err`.
- During reset:
  - `o_us_ready`=0 and `o_chunk_valid`=0 (gated combinationally);
  - `o_chunk_size`=0, `o_chunk_last`=0, `o_clip_err`=0;
  - `o_chunk`=all '0.
- Buffer storage is not reset.
- Reset mid-frame discards all buffered data and any pending `last`.
- Latency: a fragment accepted at edge t contributes to `o_chunk`/`o_chunk_valid` from cycle t+1.
- Space freed by a pop at edge t is reflected in `o_us_ready` from cycle t+1.
- `o_chunk*` hold stable while `o_chunk_valid`=1 and `i_ds_ready`=0. The upstream side may still add data during that stall.
  - Exception: if the added data raises `cnt` above `S_OUT`, `o_chunk_size` stays `S_OUT`.
  - Contents at indices < the current size are unchanged.

## Test plan
Defaults: `S_MAX_IN`=4, `S_OUT`=8, `BUF_CAP`=16, data = running counter.
- Reset check: hold `i_sync_rst_n`=0 with random inputs -> all outputs 0. Release -> `o_us_ready`=1 next cycle, `o_chunk_valid`=0.
- Packing, `i_ds_ready`=1: fragments of sizes 3,3,3,3 -> one chunk {0..7}, size 8, `last`=0, valid the cycle after the 3rd accept. `cnt` ends at 4.
- Flush: sizes 4 then 2 with `last` -> chunk {0..5}, size 6, `last`=1, elements 6..7 read as 0. `o_us_ready`=0 from the accept of the `last` fragment until the cycle after the pop.
- Backpressure and wrap:
  - `i_ds_ready`=0, size-4 fragments -> 4 accepted (cnt=16), then `o_us_ready`=0.
  - Pop 2 chunks, push 3 more -> chunk order {16..23} after {0..7},{8..15}, exercising wrap with correct order.
- Edge frames:
  - sizes 4,4 with `last` -> single chunk, size 8, `last`=1.
  - Then a size-0 fragment with `last` at `cnt`=0 -> chunk size 0, `last`=1.
- Clip and mid-stream reset:
  - `i_frag_size`=7 -> 4 elements stored, `o_clip_err`=1 and sticky.
  - Reset while cnt=5 and `last_pend`=1 -> all cleared, next frame starts from `rd_ptr`=0.

Source files
------------

// File: rtl/fragment_to_chunk_flush.sv
// Packs variable-size fragments into fixed S_OUT-element chunks; a 'last' fragment flushes a short final chunk.
// Circular element buffer with valid/ready on both sides; upstream is stalled while a frame end is pending.
module fragment_to_chunk_flush #(
  parameter int S_MAX_IN = 4,
  parameter int S_OUT    = 8,
  parameter int BUF_CAP  = 2 * S_OUT,
  parameter type T       = logic
) (
  input  logic                         i_clk,
  input  logic                         i_sync_rst_n,
  input  logic                         i_frag_valid,
  input  logic [$clog2(S_MAX_IN+1)-1:0] i_frag_size,
  input  logic                         i_frag_last,
  input  T [S_MAX_IN-1:0]              i_frag,
  output logic                         o_us_ready,
  input  logic                         i_ds_ready,
  output logic                         o_chunk_valid,
  output T [S_OUT-1:0]                 o_chunk,
  output logic [$clog2(S_OUT+1)-1:0]   o_chunk_size,
  output logic                         o_chunk_last,
  output logic                         o_clip_err
);

  localparam int FSW = $clog2(S_MAX_IN + 1);
  localparam int OSW = $clog2(S_OUT + 1);
  localparam int PW  = (BUF_CAP > 1) ? $clog2(BUF_CAP) : 1;
  localparam int CW  = $clog2(BUF_CAP + 1);
  localparam logic [PW+1:0] CAP_P = (PW+2)'(BUF_CAP);

  if (S_MAX_IN < 1) begin : g_chk_in
    $error("S_MAX_IN must be >= 1");
  end
  if (S_OUT < S_MAX_IN) begin : g_chk_out
    $error("S_OUT must be >= S_MAX_IN");
  end
  if (BUF_CAP < S_OUT + S_MAX_IN) begin : g_chk_cap
    $error("BUF_CAP must be >= S_OUT + S_MAX_IN");
  end

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_pend_q, last_pend_d;
  logic           clip_err_q, clip_err_d;
  T               mem_q [BUF_CAP];
  T               mem_d [BUF_CAP];

  logic           push, pop, clip;
  logic [FSW-1:0] sz;
  logic [OSW-1:0] out_sz;

  // base < BUF_CAP and off <= BUF_CAP, so one conditional subtract wraps correctly
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW:0] off);
    logic [PW+1:0] s;
    s = {2'b00, base} + {1'b0, off};
    if (s >= CAP_P) s = s - CAP_P;
    return PW'(s);
  endfunction

  always_comb begin
    clip          = i_frag_size > FSW'(S_MAX_IN);
    sz            = clip ? FSW'(S_MAX_IN) : i_frag_size;
    out_sz        = (cnt_q >= CW'(S_OUT)) ? OSW'(S_OUT) : OSW'(cnt_q);
    o_us_ready    = i_sync_rst_n && !last_pend_q && ((CW'(BUF_CAP) - cnt_q) >= CW'(S_MAX_IN));
    o_chunk_valid = i_sync_rst_n && ((cnt_q >= CW'(S_OUT)) || last_pend_q);
    o_chunk_size  = i_sync_rst_n ? out_sz : '0;
    o_chunk_last  = i_sync_rst_n && last_pend_q && (cnt_q <= CW'(S_OUT));
    o_clip_err    = i_sync_rst_n && clip_err_q;
    push          = i_frag_valid && o_us_ready;
    pop           = o_chunk_valid && i_ds_ready;
  end

  always_comb begin
    for (int k = 0; k < S_OUT; k++) begin
      o_chunk[k] = (OSW'(k) < o_chunk_size) ? mem_q[wrap_add(rd_ptr_q, (PW+1)'(k))] : '0;
    end
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_pend_d = last_pend_q;
    clip_err_d  = clip_err_q | (push & clip);
    if (push) begin
      for (int k = 0; k < S_MAX_IN; k++) begin
        if (FSW'(k) < sz) mem_d[wrap_add(wr_ptr_q, (PW+1)'(k))] = i_frag[k];
      end
      wr_ptr_d = wrap_add(wr_ptr_q, (PW+1)'(sz));
    end
    if (pop) rd_ptr_d = wrap_add(rd_ptr_q, (PW+1)'(out_sz));
    // pop and push never both touch last_pend: a push requires it to be clear
    if (pop && o_chunk_last) last_pend_d = 1'b0;
    if (push && i_frag_last) last_pend_d = 1'b1;
    cnt_d = cnt_q + (push ? CW'(sz) : '0) - (pop ? CW'(out_sz) : '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
      clip_err_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
      clip_err_q  <= clip_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fragment_to_chunk_flush.sv
// Directed bench for fragment_to_chunk_flush with 8-bit elements carrying a running counter.
module tb_fragment_to_chunk_flush;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frag_vld, frag_last, ds_rdy;
  logic [2:0]       frag_size;
  logic [3:0][7:0]  frag;
  logic             us_rdy, chunk_vld, chunk_last, clip_err;
  logic [7:0][7:0]  chunk;
  logic [3:0]       chunk_size;

  int errors = 0;
  int checks = 0;
  int nxt    = 0;

  always #5 clk = ~clk;

  fragment_to_chunk_flush #(.S_MAX_IN(4), .S_OUT(8), .BUF_CAP(16), .T(logic [7:0])) dut (
    .i_clk        (clk),
    .i_sync_rst_n (rst_n),
    .i_frag_valid (frag_vld),
    .i_frag_size  (frag_size),
    .i_frag_last  (frag_last),
    .i_frag       (frag),
    .o_us_ready   (us_rdy),
    .i_ds_ready   (ds_rdy),
    .o_chunk_valid(chunk_vld),
    .o_chunk      (chunk),
    .o_chunk_size (chunk_size),
    .o_chunk_last (chunk_last),
    .o_clip_err   (clip_err)
  );

  function automatic logic [63:0] exp_chunk(input int start, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = 8'(start + k);
    return r;
  endfunction

  task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input int sz, input logic last,
                         input logic [63:0] dat);
    chk_bit({tag, ".vld"}, chunk_vld, vld);
    chk_vec({tag, ".size"}, 64'(chunk_size), 64'(sz));
    chk_bit({tag, ".last"}, chunk_last, last);
    chk_vec({tag, ".data"}, chunk, dat);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    frag_vld  = 1'b0;
    frag_size = '0;
    frag_last = 1'b0;
    frag      = '0;
  endtask

  // Presents one fragment for exactly one edge; it must be accepted there.
  task automatic send(input int size, input logic last);
    frag_vld  = 1'b1;
    frag_size = 3'(size);
    frag_last = last;
    for (int k = 0; k < 4; k++) frag[k] = 8'(nxt + k);
    #1;
    chk_bit("send.us_rdy", us_rdy, 1'b1);
    @(posedge clk);
    #1;
    idle_inputs();
    nxt += (size > 4) ? 4 : size;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    ds_rdy = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    nxt = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    ds_rdy = 1'b0;
    idle_inputs();

    // Reset held with random inputs: everything reads zero
    for (int c = 0; c < 3; c++) begin
      frag_vld  = 1'($urandom);
      frag_size = 3'($urandom);
      frag_last = 1'($urandom);
      frag      = 32'($urandom);
      ds_rdy    = 1'($urandom);
      step();
      chk_bit("rst.us_rdy", us_rdy, 1'b0);
      chk_out("rst", 1'b0, 0, 1'b0, 64'd0);
      chk_bit("rst.clip", clip_err, 1'b0);
    end
    idle_inputs();
    ds_rdy = 1'b0;
    rst_n  = 1'b1;
    #1;
    chk_bit("rel.us_rdy", us_rdy, 1'b1);
    chk_bit("rel.vld", chunk_vld, 1'b0);

    // Packing with downstream always ready
    ds_rdy = 1'b1;
    send(3, 1'b0);
    send(3, 1'b0);
    chk_bit("pack6.vld", chunk_vld, 1'b0);
    send(3, 1'b0);
    chk_out("pack9", 1'b1, 8, 1'b0, exp_chunk(0, 8));
    send(3, 1'b0);
    chk_out("pack_rem", 1'b0, 4, 1'b0, exp_chunk(8, 4));

    // Flush of a short frame
    do_reset();
    send(4, 1'b0);
    send(2, 1'b1);
    chk_bit("flush.us_rdy", us_rdy, 1'b0);
    chk_out("flush", 1'b1, 6, 1'b1, exp_chunk(0, 6));
    step();
    chk_bit("flush_stall.us_rdy", us_rdy, 1'b0);
    chk_out("flush_stall", 1'b1, 6, 1'b1, exp_chunk(0, 6));
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    chk_bit("flush_pop.us_rdy", us_rdy, 1'b1);
    chk_bit("flush_pop.vld", chunk_vld, 1'b0);

    // Backpressure fills the buffer, then drain with wrap
    do_reset();
    for (int i = 0; i < 4; i++) send(4, 1'b0);
    chk_bit("full.us_rdy", us_rdy, 1'b0);
    chk_out("full", 1'b1, 8, 1'b0, exp_chunk(0, 8));
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    chk_bit("pop1.us_rdy", us_rdy, 1'b1);
    chk_out("pop1", 1'b1, 8, 1'b0, exp_chunk(8, 8));
    send(4, 1'b0);
    send(4, 1'b0);
    chk_bit("refill.us_rdy", us_rdy, 1'b0);
    chk_out("refill_stable", 1'b1, 8, 1'b0, exp_chunk(8, 8));
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    chk_out("wrap", 1'b1, 8, 1'b0, exp_chunk(16, 8));
    send(4, 1'b0);
    chk_out("wrap_stable", 1'b1, 8, 1'b0, exp_chunk(16, 8));
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    chk_out("wrap_rem", 1'b0, 4, 1'b0, exp_chunk(24, 4));

    // Frame of exactly one chunk, then an empty frame
    do_reset();
    send(4, 1'b0);
    send(4, 1'b1);
    chk_bit("exact.us_rdy", us_rdy, 1'b0);
    chk_out("exact", 1'b1, 8, 1'b1, exp_chunk(0, 8));
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    chk_bit("exact_pop.us_rdy", us_rdy, 1'b1);
    chk_out("exact_pop", 1'b0, 0, 1'b0, 64'd0);
    send(0, 1'b0);
    chk_out("zero_nolast", 1'b0, 0, 1'b0, 64'd0);
    send(0, 1'b1);
    chk_bit("empty.us_rdy", us_rdy, 1'b0);
    chk_out("empty", 1'b1, 0, 1'b1, 64'd0);
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    chk_bit("empty_pop.us_rdy", us_rdy, 1'b1);
    chk_bit("empty_pop.vld", chunk_vld, 1'b0);

    // Clipped size, sticky error, then reset mid-frame
    do_reset();
    send(7, 1'b0);
    chk_bit("clip.flag", clip_err, 1'b1);
    chk_out("clip", 1'b0, 4, 1'b0, exp_chunk(0, 4));
    send(4, 1'b0);
    send(4, 1'b0);
    chk_bit("clip.sticky", clip_err, 1'b1);
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    send(1, 1'b1);
    chk_out("pre_rst", 1'b1, 5, 1'b1, exp_chunk(8, 5));
    chk_bit("pre_rst.clip", clip_err, 1'b1);
    chk_bit("pre_rst.us_rdy", us_rdy, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 0, 1'b0, 64'd0);
    chk_bit("mid_rst.us_rdy", us_rdy, 1'b0);
    chk_bit("mid_rst.clip", clip_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_bit("post_rst.us_rdy", us_rdy, 1'b1);
    chk_out("post_rst", 1'b0, 0, 1'b0, 64'd0);
    chk_bit("post_rst.clip", clip_err, 1'b0);
    send(3, 1'b1);
    chk_out("new_frame", 1'b1, 3, 1'b1, exp_chunk(13, 3));
    ds_rdy = 1'b1;
    step();
    ds_rdy = 1'b0;
    chk_bit("new_frame_pop.vld", chunk_vld, 1'b0);
    chk_bit("new_frame_pop.us_rdy", us_rdy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
